wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the writeback stage plus the integer register file it writes.
- Selects the writeback value from the MEM/WB memory-read data or ALU result, and commits it to one of 16 64-bit registers.
- Serves the ID stage's two read ports, with same-cycle write-through bypass.
- Keeps a retired-instruction counter for bench and debug visibility.

---
 rtl/wb_regfile.sv | 87 ++++++++
 tb/tb_wb_regfile.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and integer register file.
// Picks the MEM/WB writeback value, commits it to one of NUM_REGS registers
// (register 0 is hardwired to zero), serves two combinational read ports with
// write-through bypass, and counts retired non-bubble instructions.
`timescale 1ns/1ps

module wb_regfile #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic              wb,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] input_mux1,
    input  logic [DATA_W-1:0] input_mux2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    output logic [DATA_W-1:0] readdata1,
    output logic [DATA_W-1:0] readdata2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [CNT_W-1:0]  retired_count
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  retired_q;

    // Writeback value select; keeps following the mux even while reset is high.
    assign wb_data = memtoreg ? input_mux1 : input_mux2;

    // Qualified write enable: real instruction, regwrite set, not x0, and the
    // bypass/write path is fully suppressed while reset is asserted.
    assign wb_en = !reset && wb_valid && wb && (write_register != '0);

    // Register storage: cleared asynchronously, written one cycle after select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the whole array is in the async reset on purpose -- reads must
            // return 0 the moment reset rises, not after the next edge.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            regs[write_register] <= wb_data;
        end
    end

    // Read port 1: x0 reads zero, then bypass, then storage.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch forms.
        readdata1 = regs[read_register1];
        if (read_register1 == '0) begin
            readdata1 = '0;
        end else if (wb_en && (write_register == read_register1)) begin
            readdata1 = wb_data;
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        readdata2 = regs[read_register2];
        if (read_register2 == '0) begin
            readdata2 = '0;
        end else if (wb_en && (write_register == read_register2)) begin
            readdata2 = wb_data;
        end
    end

    // Retired-instruction counter: every valid slot counts, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (wb_valid) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile (reset, write/read, bypass,
// x0 protection, bubbles, counter wrap). Counter is shrunk to 4 bits so the
// wrap is reached in a handful of cycles.
`timescale 1ns/1ps

module tb_wb_regfile;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 4;

    logic              clk;
    logic              reset;
    logic              wb_valid;
    logic              wb;
    logic              memtoreg;
    logic [DATA_W-1:0] input_mux1;
    logic [DATA_W-1:0] input_mux2;
    logic [ADDR_W-1:0] write_register;
    logic [ADDR_W-1:0] read_register1;
    logic [ADDR_W-1:0] read_register2;
    logic [DATA_W-1:0] readdata1;
    logic [DATA_W-1:0] readdata2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [CNT_W-1:0]  retired_count;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb             (wb),
        .memtoreg       (memtoreg),
        .input_mux1     (input_mux1),
        .input_mux2     (input_mux2),
        .write_register (write_register),
        .read_register1 (read_register1),
        .read_register2 (read_register2),
        .readdata1      (readdata1),
        .readdata2      (readdata2),
        .wb_data        (wb_data),
        .wb_en          (wb_en),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One rising edge, then step 1ns past it before touching inputs or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        wb_valid       = 1'b1;
        wb             = 1'b1;
        memtoreg       = 1'b0;
        input_mux1     = 64'h0;
        input_mux2     = 64'h5555;
        write_register = 4'd5;
        read_register1 = 4'd5;
        read_register2 = 4'd0;

        // During reset: bypass suppressed, outputs zero, wb_data follows mux.
        #2;
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_rd1", readdata1, 64'd0);
        check("rst_cnt", 64'(retired_count), 64'd0);
        check("rst_wb_data", wb_data, 64'h5555);

        // Release reset, then fill reg[5].
        @(negedge clk);
        reset      = 1'b0;
        input_mux2 = 64'hDEAD_BEEF;
        tick();
        wb_valid = 1'b0;
        #1;
        check("fill_r5", readdata1, 64'hDEAD_BEEF);
        check("fill_cnt", 64'(retired_count), 64'd1);

        // Mid-cycle reset clears storage immediately.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_r5", readdata1, 64'd0);
        check("async_rst_cnt", 64'(retired_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic ALU write to reg[3].
        wb_valid       = 1'b1;
        wb             = 1'b1;
        memtoreg       = 1'b0;
        input_mux1     = 64'hBAD0;
        input_mux2     = 64'h1234;
        write_register = 4'd3;
        read_register1 = 4'd1;
        tick();
        wb_valid       = 1'b0;
        read_register1 = 4'd3;
        #1;
        check("basic_rd1", readdata1, 64'h1234);
        check("basic_cnt", 64'(retired_count), 64'd1);

        // Memory select with bypass on both ports.
        wb_valid       = 1'b1;
        memtoreg       = 1'b1;
        input_mux1     = 64'hAAAA_5555_0000_FFFF;
        input_mux2     = 64'h1111;
        write_register = 4'd7;
        read_register1 = 4'd7;
        read_register2 = 4'd7;
        #1;
        check("mem_wb_data", wb_data, 64'hAAAA_5555_0000_FFFF);
        check("mem_wb_en", 64'(wb_en), 64'd1);
        check("byp_rd1", readdata1, 64'hAAAA_5555_0000_FFFF);
        check("byp_rd2", readdata2, 64'hAAAA_5555_0000_FFFF);
        read_register2 = 4'd3;
        #1;
        check("nobyp_rd2", readdata2, 64'h1234);
        tick();
        wb_valid = 1'b0;
        #1;
        check("stored_r7", readdata1, 64'hAAAA_5555_0000_FFFF);
        check("mem_cnt", 64'(retired_count), 64'd2);

        // x0 protection.
        wb_valid       = 1'b1;
        wb             = 1'b1;
        memtoreg       = 1'b0;
        input_mux2     = 64'hFFFF;
        write_register = 4'd0;
        read_register1 = 4'd0;
        read_register2 = 4'd3;
        #1;
        check("x0_wb_en", 64'(wb_en), 64'd0);
        check("x0_rd1_same", readdata1, 64'd0);
        check("x0_rd2_other", readdata2, 64'h1234);
        tick();
        wb_valid = 1'b0;
        #1;
        check("x0_rd1_after", readdata1, 64'd0);
        check("x0_cnt", 64'(retired_count), 64'd3);

        // Bubble: no write, no count.
        wb_valid       = 1'b0;
        wb             = 1'b1;
        input_mux2     = 64'h99;
        write_register = 4'd4;
        read_register1 = 4'd4;
        #1;
        check("bub_wb_en", 64'(wb_en), 64'd0);
        check("bub_rd1_same", readdata1, 64'd0);
        tick();
        check("bub_rd1_after", readdata1, 64'd0);
        check("bub_cnt", 64'(retired_count), 64'd3);

        // Valid non-writing instruction: counts, no write.
        wb_valid   = 1'b1;
        wb         = 1'b0;
        input_mux2 = 64'h77;
        #1;
        check("nw_wb_en", 64'(wb_en), 64'd0);
        tick();
        check("nw_rd1", readdata1, 64'd0);
        check("nw_cnt", 64'(retired_count), 64'd4);

        // Counter wrap: 11 more valid edges reach 15, one more wraps to 0.
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        check("cnt_max", 64'(retired_count), 64'd15);
        tick();
        check("cnt_wrap", 64'(retired_count), 64'd0);
        wb_valid = 1'b0;
        tick();
        check("cnt_hold", 64'(retired_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
